// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU; one operation in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise req0 has fixed priority.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [6:0]  req0_funct7,
    input  logic [2:0]  req0_funct3,
    input  logic [4:0]  req0_aluop,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [6:0]  req1_funct7,
    input  logic [2:0]  req1_funct3,
    input  logic [4:0]  req1_aluop,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [6:0]  alu_funct7,
    output logic [2:0]  alu_funct3,
    output logic [4:0]  alu_aluop,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(EXEC_CYCLES - 1);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        owner_q;
    logic [6:0]  funct7_q, funct7_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  aluop_q, aluop_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] rsp_result_q;
    logic        rsp_zero_q, rsp0_valid_q, rsp1_valid_q, busy_q;
    logic        gnt0, gnt1, accept, sel1, rsp_done;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_q;

    // On contention, serve the requester that was not granted last.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || last_q);
        gnt1 = req1_valid && (!req0_valid || !last_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_q <= 1'b1;
        else if (accept) last_q <= sel1;
    end
`else
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid && !req0_valid;
    end
`endif

    // Ready is combinational so a request is accepted in the cycle it is presented.
    assign req0_ready = rst_n && (state_q == IDLE) && gnt0;
    assign req1_ready = rst_n && (state_q == IDLE) && gnt1;
    assign accept     = req0_ready || req1_ready;
    assign sel1       = req1_ready;
    assign rsp_done   = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

    always_comb begin
        funct7_d = sel1 ? req1_funct7 : req0_funct7;
        funct3_d = sel1 ? req1_funct3 : req0_funct3;
        aluop_d  = sel1 ? req1_aluop  : req0_aluop;
        a_d      = sel1 ? req1_a      : req0_a;
        b_d      = sel1 ? req1_b      : req0_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            funct7_q     <= '0;
            funct3_q     <= '0;
            aluop_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct7_q <= funct7_d;
                        funct3_q <= funct3_d;
                        aluop_q  <= aluop_d;
                        a_q      <= a_d;
                        b_q      <= b_d;
                        owner_q  <= sel1;
                        cnt_q    <= CNT_INIT;
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == 2'd0) begin
                        rsp_result_q <= alu_result;
                        rsp_zero_q   <= alu_zero;
                        rsp0_valid_q <= !owner_q;
                        rsp1_valid_q <= owner_q;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    // Only the owner's ready can complete; rsp_valid_q is already owner-qualified.
                    if (rsp_done) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_funct7 = funct7_q;
    assign alu_funct3 = funct3_q;
    assign alu_aluop  = aluop_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: driver pushes expected responses, negedge monitor checks.
module tb_alu_arbiter;
    localparam int EC = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0]  req0_funct7, req1_funct7, alu_funct7;
    logic [2:0]  req0_funct3, req1_funct3, alu_funct3;
    logic [4:0]  req0_aluop, req1_aluop, alu_aluop;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
    logic        alu_zero, rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, rsp_zero, busy;

    // Second instance with the longest execution window.
    logic        r4_valid, r4_ready, r4_rsp_valid, r4_rsp1_valid, r4_busy, r4_zero, r4_alu_zero, r4_ready1;
    logic [6:0]  r4_funct7, r4_alu_funct7;
    logic [2:0]  r4_funct3, r4_alu_funct3;
    logic [4:0]  r4_aluop, r4_alu_aluop;
    logic [31:0] r4_a, r4_b, r4_alu_a, r4_alu_b, r4_alu_result, r4_result;
    logic        tie0 = 1'b0;
    logic [6:0]  tie7 = '0;
    logic [2:0]  tie3 = '0;
    logic [4:0]  tie5 = '0;
    logic [31:0] tie32 = '0;
    logic        tie1 = 1'b1;

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b01000, OP_AND = 5'b01100,
                           OP_OR = 5'b01101, OP_XOR = 5'b01110;

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a + b;
        endcase
    endfunction

    assign alu_result    = ref_alu(alu_aluop, alu_a, alu_b);
    assign alu_zero      = (alu_result == 32'd0);
    assign r4_alu_result = ref_alu(r4_alu_aluop, r4_alu_a, r4_alu_b);
    assign r4_alu_zero   = (r4_alu_result == 32'd0);

    alu_arbiter #(.EXEC_CYCLES(EC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct7(req0_funct7),
        .req0_funct3(req0_funct3), .req0_aluop(req0_aluop), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct7(req1_funct7),
        .req1_funct3(req1_funct3), .req1_aluop(req1_aluop), .req1_a(req1_a), .req1_b(req1_b),
        .alu_funct7(alu_funct7), .alu_funct3(alu_funct3), .alu_aluop(alu_aluop),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid),
        .rsp1_ready(rsp1_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r4_valid), .req0_ready(r4_ready), .req0_funct7(r4_funct7),
        .req0_funct3(r4_funct3), .req0_aluop(r4_aluop), .req0_a(r4_a), .req0_b(r4_b),
        .req1_valid(tie0), .req1_ready(r4_ready1), .req1_funct7(tie7),
        .req1_funct3(tie3), .req1_aluop(tie5), .req1_a(tie32), .req1_b(tie32),
        .alu_funct7(r4_alu_funct7), .alu_funct3(r4_alu_funct3), .alu_aluop(r4_alu_aluop),
        .alu_a(r4_alu_a), .alu_b(r4_alu_b), .alu_result(r4_alu_result), .alu_zero(r4_alu_zero),
        .rsp0_valid(r4_rsp_valid), .rsp0_ready(tie1), .rsp1_valid(r4_rsp1_valid),
        .rsp1_ready(tie1), .rsp_result(r4_result), .rsp_zero(r4_zero), .busy(r4_busy)
    );

    typedef struct {
        logic        owner;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   acc0, acc1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: grant rules, occupancy and response timing from plain bookkeeping.
    logic m_infl, m_owner, m_last, g0, g1, exp_v;
    int   m_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_infl = 1'b0;
            m_last = 1'b1;
            sb_q.delete();
            chk1("rst_req0_ready", req0_ready, 1'b0);
            chk1("rst_req1_ready", req1_ready, 1'b0);
            chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
            chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk32("rst_rsp_result", rsp_result, 32'd0);
            chk32("rst_alu_a", alu_a, 32'd0);
        end else begin
            g0 = 1'b0;
            g1 = 1'b0;
            if (!m_infl) begin
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    g0 = m_last;
                    g1 = !m_last;
`else
                    g0 = 1'b1;
`endif
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid;
                end
            end
            chk1("req0_ready", req0_ready, g0);
            chk1("req1_ready", req1_ready, g1);
            chk1("busy", busy, m_infl);
            if (!m_infl) begin
                chk1("idle_rsp0_valid", rsp0_valid, 1'b0);
                chk1("idle_rsp1_valid", rsp1_valid, 1'b0);
                if (g0 || g1) begin
                    m_infl = 1'b1;
                    m_owner = g1;
                    m_last = g1;
                    m_acc = cyc;
                end
            end else begin
                exp_v = (cyc >= m_acc + EC + 1);
                chk1("rsp0_valid", rsp0_valid, exp_v && !m_owner);
                chk1("rsp1_valid", rsp1_valid, exp_v && m_owner);
                if (sb_q.size() == 0) begin
                    chk1("scoreboard_entry", 1'b0, 1'b1);
                end else if (!exp_v) begin
                    chk32("alu_a", alu_a, sb_q[0].a);
                    chk32("alu_b", alu_b, sb_q[0].b);
                    chk32("alu_funct3", 32'(alu_funct3), 32'(sb_q[0].f3));
                end else begin
                    chk1("rsp_owner", m_owner, sb_q[0].owner);
                    chk32("rsp_result", rsp_result, sb_q[0].res);
                    chk1("rsp_zero", rsp_zero, sb_q[0].zero);
                    if (m_owner ? rsp1_ready : rsp0_ready) begin
                        void'(sb_q.pop_front());
                        m_infl = 1'b0;
                    end
                end
            end
        end
    end

    // One clock of stimulus: observe accepts at the negedge, then release accepted requests.
    task automatic step();
        exp_t e;
        acc0 = 1'b0;
        acc1 = 1'b0;
        @(negedge clk);
        if (rst_n && req0_valid && req0_ready) begin
            e.owner = 1'b0; e.a = req0_a; e.b = req0_b; e.f3 = req0_funct3;
            e.res = ref_alu(req0_aluop, req0_a, req0_b); e.zero = (e.res == 32'd0);
            sb_q.push_back(e);
            grant_log.push_back(0);
            acc0 = 1'b1;
        end
        if (rst_n && req1_valid && req1_ready) begin
            e.owner = 1'b1; e.a = req1_a; e.b = req1_b; e.f3 = req1_funct3;
            e.res = ref_alu(req1_aluop, req1_a, req1_b); e.zero = (e.res == 32'd0);
            sb_q.push_back(e);
            grant_log.push_back(1);
            acc1 = 1'b1;
        end
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic issue(input int n, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = (op == OP_AND) ? 3'b111 : (op == OP_OR) ? 3'b110 : (op == OP_XOR) ? 3'b100 : 3'b000;
        f7 = (op == OP_SUB) ? 7'b0100000 : 7'b0000000;
        if (n == 0) begin
            req0_valid = 1'b1; req0_aluop = op; req0_funct3 = f3; req0_funct7 = f7; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_aluop = op; req1_funct3 = f3; req1_funct7 = f7; req1_a = a; req1_b = b;
        end
    endtask

    task automatic issue_rand(input int n);
        logic [4:0] ops[5];
        logic [31:0] a;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
        a = $urandom;
        issue(n, ops[$urandom_range(0, 4)], a, ($urandom_range(0, 3) == 0) ? a : $urandom);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((n == 0) ? rsp0_valid : rsp1_valid) return;
            step();
        end
        chk1("wait_rsp_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!req0_valid && !req1_valid && !busy) return;
            step();
        end
        chk1("drain_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int lat;
        int exp_g[4];
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        issue(0, OP_ADD, 0, 0); issue(1, OP_ADD, 0, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        r4_valid = 1'b0; r4_funct7 = '0; r4_funct3 = '0; r4_aluop = '0; r4_a = '0; r4_b = '0;
        repeat (3) step();
        chk32("rst_alu_b", alu_b, 32'd0);
        chk1("rst_rsp_zero", rsp_zero, 1'b0);
        rst_n = 1'b1;

        // ADD 5+7 from req0, then SUB 9-9 from req1.
        issue(0, OP_ADD, 32'd5, 32'd7);
        wait_rsp(0, 10);
        chk32("add_result", rsp_result, 32'd12);
        chk1("add_zero", rsp_zero, 1'b0);
        chk1("add_rsp1_valid", rsp1_valid, 1'b0);
        drain(10);
        issue(1, OP_SUB, 32'd9, 32'd9);
        wait_rsp(1, 10);
        chk32("sub_result", rsp_result, 32'd0);
        chk1("sub_zero", rsp_zero, 1'b1);
        chk1("sub_rsp0_valid", rsp0_valid, 1'b0);
        drain(10);

        // Both requesters valid continuously.
        grant_log.delete();
        for (int i = 0; i < 60 && grant_log.size() < 4; i++) begin
            if (!req0_valid) issue_rand(0);
            if (!req1_valid) issue_rand(1);
            step();
        end
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        chk32("grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk32($sformatf("grant_%0d", i), 32'(grant_log[i]), 32'(exp_g[i]));
        req0_valid = 1'b0;
        drain(40);

        // Response backpressure on requester 0.
        rsp0_ready = 1'b0;
        issue(0, OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A);
        for (int i = 0; i < 10 && !acc0; i++) step();
        issue(1, OP_ADD, 32'd1, 32'd2);
        wait_rsp(0, 10);
        held = rsp_result;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("bp_rsp0_valid", rsp0_valid, 1'b1);
            chk32("bp_rsp_result", rsp_result, held);
            chk1("bp_busy", busy, 1'b1);
            chk1("bp_req0_ready", req0_ready, 1'b0);
            chk1("bp_req1_ready", req1_ready, 1'b0);
        end
        rsp0_ready = 1'b1;
        drain(20);

        // Reset during EXEC abandons the operation.
        issue(0, OP_ADD, 32'd100, 32'd23);
        for (int i = 0; i < 10 && !acc0; i++) step();
        #1 rst_n = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk32("mid_rst_alu_a", alu_a, 32'd0);
        chk1("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("post_rst_no_rsp", rsp0_valid, 1'b0);
        end
        issue(0, OP_ADD, 32'd3, 32'd4);
        wait_rsp(0, 10);
        chk32("post_rst_result", rsp_result, 32'd7);
        drain(10);

        // Randomized traffic with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid && $urandom_range(0, 2) == 0) issue_rand(0);
            if (!req1_valid && $urandom_range(0, 2) == 0) issue_rand(1);
            step();
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b0;
        drain(40);

        // Four-cycle execution window instance.
        r4_valid = 1'b1; r4_aluop = OP_AND; r4_funct3 = 3'b111; r4_funct7 = '0;
        r4_a = 32'hFFFF_FFFF; r4_b = 32'h0F0F_0F0F;
        @(negedge clk);
        chk1("ec4_accept", r4_ready, 1'b1);
        @(posedge clk);
        #1 r4_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (r4_rsp_valid) begin
                lat = i;
                break;
            end
        end
        chk32("ec4_latency", 32'(lat), 32'd5);
        chk32("ec4_result", r4_result, 32'h0F0F_0F0F);
        chk1("ec4_zero", r4_zero, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
